// File: rtl/reg_file.sv
// Multi-word register file: one write port, two independent read ports, synchronous
// active-low clear, optional write-first bypass and optional registered read outputs.
module reg_file #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              waddr_ok;
  logic [ADDR_W-1:0] raddr [2];
  logic [WIDTH-1:0]  rdata [2];

  assign waddr_ok = 32'(waddr) < DEPTH;
  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (load && waddr_ok) begin
      mem_q[waddr] <= in;
    end
  end

  // Out-of-range addresses read as zero so no X escapes for unbacked addresses.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rdata[p] = '0;
      if (32'(raddr[p]) < DEPTH) begin
        if (BYPASS && load && rst_n && (raddr[p] == waddr)) begin
          rdata[p] = in;
        end else begin
          rdata[p] = mem_q[raddr[p]];
        end
      end
    end
  end

  if (REG_OUT) begin : g_reg_out
    logic [WIDTH-1:0] out_a_q;
    logic [WIDTH-1:0] out_b_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_a_q <= '0;
        out_b_q <= '0;
      end else begin
        out_a_q <= rdata[0];
        out_b_q <= rdata[1];
      end
    end

    assign out_a = out_a_q;
    assign out_b = out_b_q;
  end else begin : g_comb_out
    assign out_a = rdata[0];
    assign out_b = rdata[1];
  end

endmodule
